// File: rtl/blink_rate_arbiter.sv
// Arbitrates left/right rate-shift requests from two sources onto one blinker.
// Define BLINK_ARB_FIXED_PRIO_EN for fixed A-over-B priority (default: round-robin).
//
// state | meaning
// IDLE  | waiting for a pending slot; picks the winner and launches the issue
// ISSUE | one cycle with grant and shift (or sat) pulses high
// HOLD  | blinker settle time, HOLD_CYCLES cycles long
module blink_rate_arbiter #(
  parameter int RATE_BITS   = 3,
  parameter int INIT_RATE   = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_left_a,
  input  logic                 req_right_a,
  input  logic                 req_left_b,
  input  logic                 req_right_b,
  output logic                 shift_left,
  output logic                 shift_right,
  output logic                 grant_a,
  output logic                 grant_b,
  output logic                 sat,
  output logic [RATE_BITS-1:0] rate,
  output logic                 busy
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [RATE_BITS-1:0] RATE_MAX  = '1;
  localparam logic [RATE_BITS-1:0] RATE_RST  = RATE_BITS'(INIT_RATE);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 pend_a, pend_a_nxt, pend_b, pend_b_nxt;
  logic                 dir_a, dir_a_nxt, dir_b, dir_b_nxt;
  logic [CNT_W-1:0]     hold_cnt, hold_cnt_nxt;
  logic [RATE_BITS-1:0] rate_nxt;
  logic                 shift_left_nxt, shift_right_nxt;
  logic                 grant_a_nxt, grant_b_nxt, sat_nxt, busy_nxt;
  logic                 win_b, win_left;
`ifndef BLINK_ARB_FIXED_PRIO_EN
  logic                 last, last_nxt;
`endif

  always_comb begin
    state_nxt       = state;
    pend_a_nxt      = pend_a;
    pend_b_nxt      = pend_b;
    dir_a_nxt       = dir_a;
    dir_b_nxt       = dir_b;
    hold_cnt_nxt    = hold_cnt;
    rate_nxt        = rate;
    shift_left_nxt  = 1'b0;
    shift_right_nxt = 1'b0;
    grant_a_nxt     = 1'b0;
    grant_b_nxt     = 1'b0;
    sat_nxt         = 1'b0;
`ifdef BLINK_ARB_FIXED_PRIO_EN
    win_b = !pend_a;
`else
    last_nxt = last;
    // last=1 means B was served most recently, so A wins a tie
    win_b = pend_b && (!pend_a || !last);
`endif
    win_left = win_b ? dir_b : dir_a;

    case (state)
      IDLE: begin
        if (pend_a || pend_b) begin
          state_nxt   = ISSUE;
          grant_a_nxt = !win_b;
          grant_b_nxt = win_b;
          if (win_b) pend_b_nxt = 1'b0;
          else       pend_a_nxt = 1'b0;
`ifndef BLINK_ARB_FIXED_PRIO_EN
          last_nxt = win_b;
`endif
          if (win_left && rate != RATE_MAX) begin
            shift_left_nxt = 1'b1;
            rate_nxt       = rate + 1'b1;
          end else if (!win_left && rate != '0) begin
            shift_right_nxt = 1'b1;
            rate_nxt        = rate - 1'b1;
          end else begin
            sat_nxt = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = HOLD_LOAD;
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt    = IDLE;
        else                hold_cnt_nxt = hold_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // capture after the winner clear so a same-edge request survives
    if (req_left_a ^ req_right_a) begin
      pend_a_nxt = 1'b1;
      dir_a_nxt  = req_left_a;
    end
    if (req_left_b ^ req_right_b) begin
      pend_b_nxt = 1'b1;
      dir_b_nxt  = req_left_b;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_a      <= 1'b0;
      pend_b      <= 1'b0;
      dir_a       <= 1'b0;
      dir_b       <= 1'b0;
      hold_cnt    <= '0;
      rate        <= RATE_RST;
      shift_left  <= 1'b0;
      shift_right <= 1'b0;
      grant_a     <= 1'b0;
      grant_b     <= 1'b0;
      sat         <= 1'b0;
      busy        <= 1'b0;
`ifndef BLINK_ARB_FIXED_PRIO_EN
      last        <= 1'b1;
`endif
    end else begin
      state       <= state_nxt;
      pend_a      <= pend_a_nxt;
      pend_b      <= pend_b_nxt;
      dir_a       <= dir_a_nxt;
      dir_b       <= dir_b_nxt;
      hold_cnt    <= hold_cnt_nxt;
      rate        <= rate_nxt;
      shift_left  <= shift_left_nxt;
      shift_right <= shift_right_nxt;
      grant_a     <= grant_a_nxt;
      grant_b     <= grant_b_nxt;
      sat         <= sat_nxt;
      busy        <= busy_nxt;
`ifndef BLINK_ARB_FIXED_PRIO_EN
      last        <= last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_blink_rate_arbiter.sv
// Directed bench for blink_rate_arbiter at default parameters.
// Expectations follow BLINK_ARB_FIXED_PRIO_EN when the build defines it.
module tb_blink_rate_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_left_a = 1'b0, req_right_a = 1'b0;
  logic       req_left_b = 1'b0, req_right_b = 1'b0;
  logic       shift_left, shift_right, grant_a, grant_b, sat, busy;
  logic [2:0] rate;

  int checks = 0;
  int errors = 0;
  int n_grants, overlap, late_b;
  int who  [4] = '{0, 0, 0, 0};
  int when [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  blink_rate_arbiter #(.RATE_BITS(3), .INIT_RATE(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_left_a(req_left_a), .req_right_a(req_right_a),
    .req_left_b(req_left_b), .req_right_b(req_right_b),
    .shift_left(shift_left), .shift_right(shift_right),
    .grant_a(grant_a), .grant_b(grant_b), .sat(sat),
    .rate(rate), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic la, input logic ra, input logic lb, input logic rb);
    req_left_a  = la;
    req_right_a = ra;
    req_left_b  = lb;
    req_right_b = rb;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic la, input logic ra, input logic lb, input logic rb);
    drive(la, ra, lb, rb);
    tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  function automatic int exp_who(input int i);
`ifdef BLINK_ARB_FIXED_PRIO_EN
    return 0;
`else
    return i % 2;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, sampled while rst is still held
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("rst_rate", 32'(rate), 2);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", 32'({shift_left, shift_right, grant_a, grant_b, sat}), 0);
    rst = 1'b0;

    // single A left
    do_reset();
    pulse(1, 0, 0, 0);
    check("s1_pre_busy", 32'(busy), 0);
    tick();
    check("s1_shl", 32'(shift_left), 1);
    check("s1_gnt_a", 32'(grant_a), 1);
    check("s1_sat", 32'(sat), 0);
    check("s1_shr", 32'(shift_right), 0);
    check("s1_rate", 32'(rate), 3);
    check("s1_busy_issue", 32'(busy), 1);
    tick();
    check("s1_shl_drop", 32'(shift_left), 0);
    check("s1_gnt_drop", 32'(grant_a), 0);
    check("s1_busy_hold", 32'(busy), 1);
    repeat (3) tick();
    check("s1_busy_hold_end", 32'(busy), 1);
    tick();
    check("s1_busy_fall", 32'(busy), 0);

    // simultaneous A left and B right
    do_reset();
    pulse(1, 0, 0, 1);
    tick();
    check("s2_gnt_a", 32'(grant_a), 1);
    check("s2_gnt_b0", 32'(grant_b), 0);
    check("s2_rate_a", 32'(rate), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2_gap", 32'(grant_a | grant_b), 0);
    end
    tick();
    check("s2_gnt_b", 32'(grant_b), 1);
    check("s2_gnt_a0", 32'(grant_a), 0);
    check("s2_shr", 32'(shift_right), 1);
    check("s2_rate_b", 32'(rate), 2);
    wait_idle();

    // saturation at the top
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(1, 0, 0, 0);
      tick();
      check("s3_up_shl", 32'(shift_left), 1);
      check("s3_up_rate", 32'(rate), 32'(3 + i));
      wait_idle();
    end
    pulse(1, 0, 0, 0);
    tick();
    check("s3_top_sat", 32'(sat), 1);
    check("s3_top_gnt", 32'(grant_a), 1);
    check("s3_top_shl", 32'(shift_left), 0);
    check("s3_top_rate", 32'(rate), 7);
    wait_idle();

    // saturation at the bottom
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pulse(0, 1, 0, 0);
      tick();
      check("s3_dn_shr", 32'(shift_right), 1);
      check("s3_dn_rate", 32'(rate), 32'(1 - i));
      wait_idle();
    end
    pulse(0, 1, 0, 0);
    tick();
    check("s3_bot_sat", 32'(sat), 1);
    check("s3_bot_gnt", 32'(grant_a), 1);
    check("s3_bot_shr", 32'(shift_right), 0);
    check("s3_bot_rate", 32'(rate), 0);
    wait_idle();

    // B overwrites its own pending direction while A is holding
    do_reset();
    pulse(1, 0, 0, 0);
    tick();
    check("s4_gnt_a", 32'(grant_a), 1);
    pulse(0, 0, 1, 0);
    tick();
    pulse(0, 0, 0, 1);
    tick();
    check("s4_early_b", 32'(grant_b), 0);
    tick();
    check("s4_early_b2", 32'(grant_b), 0);
    tick();
    check("s4_gnt_b", 32'(grant_b), 1);
    check("s4_shr", 32'(shift_right), 1);
    check("s4_shl", 32'(shift_left), 0);
    check("s4_rate", 32'(rate), 2);
    late_b = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant_b) late_b++;
    end
    check("s4_single_b", 32'(late_b), 0);

    // both directions from one requester are ignored
    do_reset();
    pulse(1, 1, 0, 0);
    tick();
    tick();
    check("s5_busy", 32'(busy), 0);
    check("s5_gnt", 32'(grant_a), 0);
    check("s5_rate", 32'(rate), 2);

    // reset in the middle of HOLD discards pending B
    do_reset();
    pulse(1, 0, 0, 0);
    tick();
    check("s6_rate_pre", 32'(rate), 3);
    pulse(0, 0, 0, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_busy", 32'(busy), 0);
    check("s6_rate", 32'(rate), 2);
    late_b = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (grant_b || busy) late_b++;
    end
    check("s6_no_b", 32'(late_b), 0);

    // continuous contention from both requesters
    do_reset();
    drive(1, 0, 1, 0);
    n_grants = 0;
    overlap  = 0;
    for (int t = 0; t < 80 && n_grants < 4; t++) begin
      tick();
      if (grant_a && grant_b) overlap++;
      if (shift_left && shift_right) overlap++;
      if (grant_a || grant_b) begin
        who[n_grants]  = grant_b ? 1 : 0;
        when[n_grants] = t;
        n_grants++;
      end
    end
    drive(0, 0, 0, 0);
    check("s7_count", 32'(n_grants), 4);
    check("s7_overlap", 32'(overlap), 0);
    for (int i = 0; i < 4; i++) check("s7_who", 32'(who[i]), 32'(exp_who(i)));
    for (int i = 1; i < 4; i++) check("s7_spacing", 32'(when[i] - when[i-1]), 6);
    check("s7_rate", 32'(rate), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
